// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode map, ALU op
// encodings, FSM state and instruction-class enums.
package cu_pkg;

   // Low four opcode bits
   localparam logic [3:0] OP_LW    = 4'h0;
   localparam logic [3:0] OP_SW    = 4'h1;
   localparam logic [3:0] OP_R_LO  = 4'h2;
   localparam logic [3:0] OP_R_HI  = 4'h9;
   localparam logic [3:0] OP_BEQ   = 4'hB;
   localparam logic [3:0] OP_BNE   = 4'hC;
   localparam logic [3:0] OP_J     = 4'hD;
   localparam logic [3:0] OP_SLT   = 4'hE;

   // ALU operation encodings, zero-extended to ALU_OP_W at the port
   localparam logic [1:0] ALU_ARITH = 2'b00;
   localparam logic [1:0] ALU_CMP   = 2'b01;
   localparam logic [1:0] ALU_ADDR  = 2'b10;
   localparam logic [1:0] ALU_SLT   = 2'b11;

   // Watchdog counter width; covers MEM_TIMEOUT up to 255
   localparam int unsigned WD_W = 8;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_ERR
   } cu_state_e;

   typedef enum logic [2:0] {
      CL_LOAD,
      CL_STORE,
      CL_ALU,
      CL_SLT,
      CL_BEQ,
      CL_BNE,
      CL_JMP,
      CL_ILL
   } cu_class_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory-port handshake between the control unit (master) and the shared
// instruction/data memory (slave).
interface multicycle_control_unit_if #(
   parameter int unsigned OPCODE_W = 4
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                ifetch;
   logic                mem_read;
   logic                mem_write;

   modport master (
      input  opcode,
      input  mem_ready,
      output ifetch,
      output mem_read,
      output mem_write
   );

   modport slave (
      output opcode,
      output mem_ready,
      input  ifetch,
      input  mem_read,
      input  mem_write
   );
endinterface

// File: rtl/cu_class_decode.sv
// Combinational opcode -> instruction class decode. Any set bit above bit 3
// is illegal. Opcode 1110 is SLT only when CU_SLT_EN is defined, otherwise
// it decodes as illegal.
module cu_class_decode
   import cu_pkg::*;
#(
   parameter int unsigned OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] op,
   output cu_class_e           cls
);

   logic [3:0] lo;
   assign lo = op[3:0];

   // Classify the latched opcode
   always_comb begin
      cls = CL_ILL;
      if ((op >> 4) == '0) begin
         if (lo >= OP_R_LO && lo <= OP_R_HI) begin
            cls = CL_ALU;
         end else begin
            case (lo)
               OP_LW:   cls = CL_LOAD;
               OP_SW:   cls = CL_STORE;
               OP_BEQ:  cls = CL_BEQ;
               OP_BNE:  cls = CL_BNE;
               OP_J:    cls = CL_JMP;
`ifdef CU_SLT_EN
               OP_SLT:  cls = CL_SLT;
`else
               OP_SLT:  cls = CL_ILL;
`endif
               default: cls = CL_ILL;
            endcase
         end
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// wait states, bus-timeout watchdog (terminal S_ERR) and illegal-opcode pulse.
// Outputs decode from state and latched opcode only; mem_ready reaches just
// ir_write/pc_write. Define CU_SLT_EN to execute opcode 1110 as SLT.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 4,
   parameter int unsigned ALU_OP_W    = 2,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multicycle_control_unit_if.master mem,
   output logic                     ir_write,
   output logic                     pc_write,
   output logic [ALU_OP_W-1:0]      alu_op,
   output logic                     alu_src,
   output logic                     reg_dst,
   output logic                     mem_to_reg,
   output logic                     reg_write,
   output logic                     beq,
   output logic                     bne,
   output logic                     jump,
   output logic                     set_less_than,
   output logic                     illegal,
   output logic                     bus_err,
   output logic                     busy
);

   // Last waiting count before the timeout edge
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

   cu_state_e           state_q;
   logic [OPCODE_W-1:0] op_q;
   logic [WD_W-1:0]     wd_q;
   logic                bus_err_q;
   cu_class_e           cls;

   cu_class_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_class_decode (
      .op  (op_q),
      .cls (cls)
   );

   // Sequencer, opcode latch, watchdog and sticky bus error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         wd_q      <= '0;
         bus_err_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_FETCH: begin
               if (mem.mem_ready) begin
                  op_q    <= mem.opcode;
                  wd_q    <= '0;
                  state_q <= S_DECODE;
               end else if (wd_q == WD_LAST) begin
                  state_q   <= S_ERR;
                  bus_err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            S_DECODE: begin
               wd_q    <= '0;
               state_q <= (cls == CL_ILL) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
               wd_q <= '0;
               case (cls)
                  CL_LOAD, CL_STORE: state_q <= S_MEM;
                  CL_ALU, CL_SLT:    state_q <= S_WB;
                  default:           state_q <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (mem.mem_ready) begin
                  wd_q    <= '0;
                  state_q <= (cls == CL_LOAD) ? S_WB : S_FETCH;
               end else if (wd_q == WD_LAST) begin
                  state_q   <= S_ERR;
                  bus_err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            S_WB: begin
               wd_q    <= '0;
               state_q <= S_FETCH;
            end
            S_ERR: begin
               wd_q    <= '0;
               state_q <= S_ERR;
            end
         endcase
      end
   end

   assign bus_err = bus_err_q;

   // Control strobes decoded from the state register and latched class
   always_comb begin
      mem.ifetch    = 1'b0;
      mem.mem_read  = 1'b0;
      mem.mem_write = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      alu_op        = '0;
      alu_src       = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      beq           = 1'b0;
      bne           = 1'b0;
      jump          = 1'b0;
      set_less_than = 1'b0;
      illegal       = 1'b0;
      busy          = (state_q != S_FETCH);
      unique case (state_q)
         S_FETCH: begin
            // Gated so no request or load appears while reset is held
            mem.ifetch = rst_n;
            ir_write   = rst_n & mem.mem_ready;
            pc_write   = rst_n & mem.mem_ready;
         end
         S_DECODE: illegal = (cls == CL_ILL);
         S_EXEC: begin
            case (cls)
               CL_ALU: begin
                  alu_op  = ALU_OP_W'(ALU_ARITH);
                  reg_dst = 1'b1;
               end
`ifdef CU_SLT_EN
               CL_SLT: begin
                  alu_op        = ALU_OP_W'(ALU_SLT);
                  set_less_than = 1'b1;
                  reg_dst       = 1'b1;
               end
`else
               // SLT never decodes here; set_less_than stays tied low
`endif
               CL_LOAD, CL_STORE: begin
                  alu_src = 1'b1;
                  alu_op  = ALU_OP_W'(ALU_ADDR);
               end
               CL_BEQ: begin
                  alu_op = ALU_OP_W'(ALU_CMP);
                  beq    = 1'b1;
               end
               CL_BNE: begin
                  alu_op = ALU_OP_W'(ALU_CMP);
                  bne    = 1'b1;
               end
               CL_JMP:  jump = 1'b1;
               default: ;
            endcase
         end
         S_MEM: begin
            alu_src       = 1'b1;
            alu_op        = ALU_OP_W'(ALU_ADDR);
            mem.mem_read  = (cls == CL_LOAD);
            mem.mem_write = (cls == CL_STORE);
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (cls == CL_LOAD);
            reg_dst    = (cls != CL_LOAD);
         end
         S_ERR: ;
      endcase
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and latches the opcode once per instruction. It issues per-state control strobes to the RISC datapath, with wait-state handshaking to a shared memory port, a bus-timeout watchdog and illegal-opcode detection. It sits between the instruction register/memory interface and the datapath muxes, register file and PC.

## Interface
- OPCODE_W, 4: opcode width, ≥4; any set bit above bit 3 makes the opcode illegal.
- ALU_OP_W, 2: alu_op width, ≥2; encodings zero-extended.
- MEM_TIMEOUT, 15: cycles of mem_ready low tolerated in FETCH or MEM before error; 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  OPCODE_W  instruction opcode from memory read data, sampled on the FETCH completion edge.
- mem_ready  in  1  memory acknowledges the current ifetch/mem_read/mem_write.
- ifetch  out  1  instruction read request.
- ir_write, pc_write  out  1  load the instruction register / PC+2 (FETCH completion cycle only).
- alu_op  out  ALU_OP_W  00 arith/logic, 01 compare-subtract, 10 address add, 11 SLT.
- alu_src, reg_dst, mem_to_reg, reg_write, mem_read, mem_write, beq, bne, jump, set_less_than  out  1 each  datapath controls.
- illegal  out  1  one-cycle pulse when an illegal opcode is decoded.
- bus_err  out  1  sticky; set on timeout.
- busy  out  1  high in every state except FETCH.

## Operation
- Opcode map (low 4 bits): 0000 LW; 0001 SW; 0010–1001 R-type; 1011 BEQ; 1100 BNE; 1101 J; 1110 SLT; 1010 and 1111 illegal.
- Outputs are decoded only from the state register and op_q. There is no combinational path from opcode to outputs. mem_ready reaches only ir_write/pc_write.
- FETCH: ifetch=1. When mem_ready=1: ir_write=1, pc_write=1, op_q<=opcode, go to DECODE.
- DECODE: one cycle, no strobes.
  - Illegal: illegal=1, go to FETCH.
  - J: go to EXEC.
  - All others: go to EXEC.
- EXEC: one cycle.
  - R-type: alu_op=00, reg_dst=1.
  - SLT: alu_op=11, set_less_than=1, reg_dst=1.
  - LW/SW: alu_src=1, alu_op=10.
  - BEQ/BNE: alu_op=01, beq or bne=1.
  - J: jump=1.
  - Next state: branches/J go to FETCH; LW/SW go to MEM; R/SLT go to WB.
- MEM: alu_src=1, alu_op=10, plus mem_read (LW) or mem_write (SW), held until mem_ready. Then LW goes to WB; SW goes to FETCH.
- WB: reg_write=1 for one cycle.
  - LW: mem_to_reg=1, reg_dst=0.
  - R/SLT: reg_dst=1, mem_to_reg=0.
  - Then go to FETCH.
- Watchdog:
  - The counter clears on entry to FETCH/MEM and on mem_ready.
  - It increments each waiting cycle. When it reaches MEM_TIMEOUT, go to ERR and set bus_err.
- ERR: all strobes 0, busy=1, terminal until rst_n low.

## Timing
- Reset (async assert): state=FETCH, op_q=0, watchdog=0, bus_err=0, illegal=0, all strobes 0. ifetch rises combinationally from FETCH after reset release.
- Zero-wait cycles per instruction: R/SLT 4, LW 5, SW 4, BEQ/BNE/J 3, illegal 2.
- Each wait cycle (mem_ready low) adds one cycle. mem_ready is ignored outside FETCH/MEM.
- mem_ready high on the same edge the watchdog hits MEM_TIMEOUT: the handshake wins and no error is raised.
- Reset asserted mid-instruction: immediate return to the reset state. No partial reg_write or mem_write is issued after the reset edge.

## Configuration
- CU_SLT_EN defined: opcode 1110 executes SLT as specified.
- CU_SLT_EN undefined:
  - 1110 is illegal and pulses illegal in DECODE.
  - set_less_than is tied to 0.
  - alu_op never takes 11.

## Structure
- Shared package cu_pkg:
  - opcode localparams (OP_LW … OP_SLT).
  - alu_op encodings.
  - state enum: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR.
  - instruction-class enum: CL_LOAD, CL_STORE, CL_ALU, CL_SLT, CL_BEQ, CL_BNE, CL_JMP, CL_ILL.
- Sub-module cu_class_decode: combinational op_q → class, honouring OPCODE_W and CU_SLT_EN.
- The FSM, watchdog and output decode stay in the top module.

## Test plan
- Reset, then opcode 0010 with mem_ready=1 continuously → ir_write on cycle 1; EXEC reg_dst=1, alu_op=00; reg_write on cycle 4; ifetch again on cycle 5.
- LW (0000) with MEM held 3 cycles by mem_ready=0 → mem_read high 4 cycles; WB mem_to_reg=1, reg_write=1; total 8 cycles.
- BEQ (1011) then J (1101) → beq=1 in EXEC only, jump=1 in EXEC only; each instruction takes 3 cycles, with no reg_write or mem_write.
- Opcode 1111, and 1110 with CU_SLT_EN undefined → illegal pulse in DECODE, return to FETCH; no datapath strobe.
- SW with mem_ready low for 15 cycles, MEM_TIMEOUT=15 → S_ERR, bus_err=1 and held; mem_write drops; only rst_n clears it.
- rst_n low during WB of an R-type → reg_write falls asynchronously, state=FETCH, bus_err=0.
